// File: rtl/sched_pkg.sv
// Shared types and defaults for the matrix-multiply core scheduler.
package sched_pkg;
  localparam int NUM_CORES_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic {IDLE, RUN} topState_e;
  typedef enum logic [2:0] {OFF, PEND, LAUNCH, GUARD, ACTIVE, FIN} slotState_e;
endpackage

// File: rtl/core_slot.sv
// Per-core launch/completion tracker: waits for ready, issues one start
// pulse, then waits for done with a two-cycle blind window after the launch.
module core_slot
  import sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic clear,
  input  logic coreReady,
  input  logic coreDone,
  output logic coreStart,
  output logic finished
);

  slotState_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OFF;
      coreStart <= 1'b0;
      finished  <= 1'b0;
    end else begin
      coreStart <= 1'b0;
      if (clear) begin
        state    <= OFF;
        finished <= 1'b0;
      end else begin
        case (state)
          OFF:    if (arm) state <= PEND;
          PEND:   if (coreReady) begin
                    state     <= LAUNCH;
                    coreStart <= 1'b1;
                  end
          // LAUNCH and GUARD skip coreDone so a level left over from the
          // previous job cannot complete this one.
          LAUNCH: state <= GUARD;
          GUARD:  state <= ACTIVE;
          ACTIVE: if (coreDone) begin
                    state    <= FIN;
                    finished <= 1'b1;
                  end
          FIN:    state <= FIN;
          default: begin
            state    <= OFF;
            finished <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Launches a job on the selected cores, waits for all of them to finish,
// and reports the run length in cycles (saturating).
module core_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] coreMask,
  input  logic [NUM_CORES-1:0] coreReady,
  input  logic [NUM_CORES-1:0] coreDone,
  output logic [NUM_CORES-1:0] coreStart,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     cycleCount
);

  topState_e            state;
  logic [NUM_CORES-1:0] maskQ;
  logic [NUM_CORES-1:0] finished;
  logic [NUM_CORES-1:0] arm;
  logic                 accept;
  logic                 allFin;
  logic                 clear;

  assign accept = (state == IDLE) && start;
  assign arm    = {NUM_CORES{accept}} & coreMask;
  // Unmasked slots never finish, so they count as finished here.
  assign allFin = &(finished | ~maskQ);
  assign clear  = (state == RUN) && allFin;

  for (genvar i = 0; i < NUM_CORES; i++) begin : gSlot
    core_slot uSlot (
      .clk       (clk),
      .rst       (rst),
      .arm       (arm[i]),
      .clear     (clear),
      .coreReady (coreReady[i]),
      .coreDone  (coreDone[i]),
      .coreStart (coreStart[i]),
      .finished  (finished[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      maskQ      <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      cycleCount <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
                state      <= RUN;
                maskQ      <= coreMask;
                ready      <= 1'b0;
                busy       <= 1'b1;
                done       <= 1'b0;
                cycleCount <= '0;
              end
        RUN: begin
          if (cycleCount != '1) cycleCount <= cycleCount + CNT_W'(1);
          if (allFin) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: directed job table plus random traffic against
// an edge-timestamp reference model; a second instance uses a 4-bit counter.
module tb_core_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] coreMask = '0;
  logic [3:0] coreReady = '0;
  logic [3:0] coreDone = '0;

  logic [3:0]  cs16, cs4;
  logic        rdy16, rdy4, busy16, busy4, done16, done4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  core_scheduler #(.NUM_CORES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .coreMask(coreMask),
    .coreReady(coreReady), .coreDone(coreDone), .coreStart(cs16),
    .ready(rdy16), .busy(busy16), .done(done16), .cycleCount(cnt16)
  );

  core_scheduler #(.NUM_CORES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .coreMask(coreMask),
    .coreReady(coreReady), .coreDone(coreDone), .coreStart(cs4),
    .ready(rdy4), .busy(busy4), .done(done4), .cycleCount(cnt4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a job is described by edge numbers. A core launches at
  // the first RUN edge that sees ready, finishes at the first edge at least
  // three edges after launch that sees done, and the job ends one edge after
  // the last core finishes. Run length is (end edge - accept edge).
  int   edgeNo = 0;
  bit   mBusy, mDone;
  int   mCount, e0;
  bit [3:0] mMask;
  int   launchE[4], finE[4];

  task automatic modelReset();
    mBusy = 0; mDone = 0; mCount = 0; mMask = '0; e0 = 0;
    for (int i = 0; i < 4; i++) begin launchE[i] = -1; finE[i] = -1; end
  endtask

  task automatic modelEdge();
    bit allFin;
    edgeNo++;
    if (!mBusy) begin
      if (start) begin
        mBusy = 1; mDone = 0; mCount = 0; e0 = edgeNo; mMask = coreMask;
        for (int i = 0; i < 4; i++) begin launchE[i] = -1; finE[i] = -1; end
      end
    end else begin
      mCount = edgeNo - e0;
      allFin = 1;
      for (int i = 0; i < 4; i++) if (mMask[i] && finE[i] < 0) allFin = 0;
      if (allFin) begin
        mBusy = 0; mDone = 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mMask[i]) begin
            if (launchE[i] < 0) begin
              if (coreReady[i]) launchE[i] = edgeNo;
            end else if (finE[i] < 0 && edgeNo >= launchE[i] + 3 && coreDone[i])
              finE[i] = edgeNo;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [3:0] es;
    int c16, c4;
    for (int i = 0; i < 4; i++) es[i] = mBusy && mMask[i] && (launchE[i] == edgeNo);
    c16 = (mCount > 65535) ? 65535 : mCount;
    c4  = (mCount > 15) ? 15 : mCount;
    check("coreStart16", cs16, es);
    check("ready16", rdy16, !mBusy);
    check("busy16", busy16, mBusy);
    check("done16", done16, mDone);
    check("cycleCount16", cnt16, c16);
    check("coreStart4", cs4, es);
    check("ready4", rdy4, !mBusy);
    check("busy4", busy4, mBusy);
    check("done4", done4, mDone);
    check("cycleCount4", cnt4, c4);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  // rd: edges after acceptance with coreReady low; dd: edges after launch
  // before coreDone rises (0 = held high from acceptance on, i.e. stale).
  typedef struct {
    logic [3:0] mask;
    int         rd;
    int         dd;
    int         expCount;
  } vec_t;

  vec_t tbl[7];

  task automatic runEntry(input vec_t v);
    int r;
    bit fin;
    start = 1'b1; coreMask = v.mask; coreReady = '0;
    coreDone = (v.dd == 0) ? 4'hF : 4'h0;
    step();
    start = 1'b0;
    r = 0; fin = 0;
    while (!fin && r < v.expCount + 20) begin
      r++;
      coreReady = (r > v.rd) ? 4'hF : 4'h0;
      if (v.dd != 0) coreDone = (r >= v.rd + 1 + v.dd) ? 4'hF : 4'h0;
      start = (r == 2 && v.expCount > 3);
      step();
      if (rdy16) fin = 1;
    end
    start = 1'b0;
    check("jobEndEdge", r, v.expCount);
    check("jobDone", done16, 1);
    check("jobCount16", cnt16, v.expCount);
    check("jobCount4", cnt4, (v.expCount > 15) ? 15 : v.expCount);
  endtask

  initial begin
    tbl[0] = '{4'b1111, 0, 10, 12};
    tbl[1] = '{4'b0010, 0, 0, 5};
    tbl[2] = '{4'b0101, 5, 10, 17};
    tbl[3] = '{4'b1000, 2, 1, 7};
    tbl[4] = '{4'b0000, 0, 3, 1};
    tbl[5] = '{4'b1111, 1, 40, 43};
    tbl[6] = '{4'b0110, 3, 3, 8};

    modelReset();
    #7;
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) runEntry(tbl[k]);

    // Reset landing on an in-flight coreStart pulse.
    start = 1'b1; coreMask = 4'hF; coreReady = 4'hF; coreDone = 4'h0;
    step();
    start = 1'b0;
    step();
    check("pulseBeforeReset", cs16, 4'hF);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
    runEntry(tbl[0]);

    for (int n = 0; n < 400; n++) begin
      start     = ($urandom_range(3) == 0);
      coreMask  = 4'($urandom);
      coreReady = 4'($urandom);
      coreDone  = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
